// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Shares a single 4-bit lab ALU (3-bit Function, 8-bit result) between two
// requesters. An idle controller arbitrates between req0 and req1, latches the
// winning operands, runs the ALU for OP_DELAY cycles and then holds the
// registered result until the consumer takes it.
//
// Parameters
//   RR_EN     1: round-robin on a tie, 0: req0 always wins a tie
//   OP_DELAY  execute cycles per op, 1..4
//
// Ports
//   Clock            rising-edge clock
//   Reset            synchronous, active-high; aborts any op in flight
//   reqN_valid       requester N has an op
//   reqN_A, reqN_B   4-bit operands
//   reqN_Function    3-bit ALU function code
//   reqN_ready       combinational grant; op accepted when valid & ready
//   res_valid        result available
//   res_data         registered 8-bit ALU result
//   res_id           requester that issued the op
//   res_ready        consumer accepts the result when res_valid & res_ready
//   busy             controller is not idle
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter bit          RR_EN    = 1'b1,
   parameter int unsigned OP_DELAY = 1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       req0_valid,
   input  logic [3:0] req0_A,
   input  logic [3:0] req0_B,
   input  logic [2:0] req0_Function,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_A,
   input  logic [3:0] req1_B,
   input  logic [2:0] req1_Function,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       res_id,
   input  logic       res_ready,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter is loaded with OP_DELAY-1 so that EXEC lasts exactly OP_DELAY cycles.
   localparam logic [1:0] CNT_INIT = 2'(OP_DELAY - 1);

   state_t     state;
   logic [1:0] cnt;
   logic       last_grant;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [2:0] op_func;
   logic       op_id;
   logic       grant1;
   logic [4:0] sum;
   logic [7:0] alu_out;

   // Arbitration: req1 wins if it is alone, or on a tie when round-robin is
   // enabled and req0 had the previous grant. Everything else goes to req0.
   always_comb begin
      grant1 = req1_valid && (!req0_valid || (RR_EN && !last_grant));
   end

   // Readys are only offered while idle and out of reset, so at most one is high.
   assign req0_ready = (state == IDLE) && !Reset && req0_valid && !grant1;
   assign req1_ready = (state == IDLE) && !Reset && grant1;
   assign busy       = (state != IDLE);

   // The shared ALU only ever sees the latched operands, so requesters are free
   // to change their inputs while an op is executing.
   always_comb begin
      sum     = {1'b0, op_a} + {1'b0, op_b};
      alu_out = 8'h00;
      case (op_func)
         3'b000:  alu_out = {3'b000, sum};
         3'b001:  alu_out = {4'h0, sum[3:0]};
         3'b010:  alu_out = {{4{op_b[3]}}, op_b};
         3'b011:  alu_out = {7'd0, |{op_a, op_b}};
         3'b100:  alu_out = {7'd0, &{op_a, op_b}};
         3'b101:  alu_out = {op_a, op_b};
         default: alu_out = 8'h00;
      endcase
   end

   // Main controller. last_grant resets to 1 so the first tie goes to req0.
   // A reset in any state drops the op in flight without ever raising res_valid.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         last_grant <= 1'b1;
         op_a       <= 4'h0;
         op_b       <= 4'h0;
         op_func    <= 3'b000;
         op_id      <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= 8'h00;
         res_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  op_a       <= grant1 ? req1_A : req0_A;
                  op_b       <= grant1 ? req1_B : req0_B;
                  op_func    <= grant1 ? req1_Function : req0_Function;
                  op_id      <= grant1;
                  last_grant <= grant1;
                  cnt        <= CNT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != 2'd0) begin
                  cnt <= cnt - 2'd1;
               end else begin
                  res_data  <= alu_out;
                  res_id    <= op_id;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Directed bench for alu_share_ctrl. Three instances cover the parameter
// corners: index 0 is round-robin with OP_DELAY=1, index 1 is fixed priority
// with OP_DELAY=1, index 2 is round-robin with OP_DELAY=4. Each instance has
// its own stimulus signals so they can be exercised independently.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

   logic       clk = 1'b0;
   logic       rst  [3];
   logic       r0v  [3];
   logic [3:0] r0a  [3];
   logic [3:0] r0b  [3];
   logic [2:0] r0f  [3];
   logic       r0r  [3];
   logic       r1v  [3];
   logic [3:0] r1a  [3];
   logic [3:0] r1b  [3];
   logic [2:0] r1f  [3];
   logic       r1r  [3];
   logic       resv [3];
   logic [7:0] resd [3];
   logic       resid[3];
   logic       resr [3];
   logic       bsy  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.RR_EN(1'b1), .OP_DELAY(1)) dut_rr (
      .Clock(clk), .Reset(rst[0]),
      .req0_valid(r0v[0]), .req0_A(r0a[0]), .req0_B(r0b[0]), .req0_Function(r0f[0]), .req0_ready(r0r[0]),
      .req1_valid(r1v[0]), .req1_A(r1a[0]), .req1_B(r1b[0]), .req1_Function(r1f[0]), .req1_ready(r1r[0]),
      .res_valid(resv[0]), .res_data(resd[0]), .res_id(resid[0]), .res_ready(resr[0]), .busy(bsy[0])
   );

   alu_share_ctrl #(.RR_EN(1'b0), .OP_DELAY(1)) dut_fixed (
      .Clock(clk), .Reset(rst[1]),
      .req0_valid(r0v[1]), .req0_A(r0a[1]), .req0_B(r0b[1]), .req0_Function(r0f[1]), .req0_ready(r0r[1]),
      .req1_valid(r1v[1]), .req1_A(r1a[1]), .req1_B(r1b[1]), .req1_Function(r1f[1]), .req1_ready(r1r[1]),
      .res_valid(resv[1]), .res_data(resd[1]), .res_id(resid[1]), .res_ready(resr[1]), .busy(bsy[1])
   );

   alu_share_ctrl #(.RR_EN(1'b1), .OP_DELAY(4)) dut_slow (
      .Clock(clk), .Reset(rst[2]),
      .req0_valid(r0v[2]), .req0_A(r0a[2]), .req0_B(r0b[2]), .req0_Function(r0f[2]), .req0_ready(r0r[2]),
      .req1_valid(r1v[2]), .req1_A(r1a[2]), .req1_B(r1b[2]), .req1_Function(r1f[2]), .req1_ready(r1r[2]),
      .res_valid(resv[2]), .res_data(resd[2]), .res_id(resid[2]), .res_ready(resr[2]), .busy(bsy[2])
   );

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one requester of one instance.
   task automatic drive(input int d, input bit id, input logic v,
                        input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
      if (id) begin
         r1v[d] = v; r1a[d] = a; r1b[d] = b; r1f[d] = f;
      end else begin
         r0v[d] = v; r0a[d] = a; r0b[d] = b; r0f[d] = f;
      end
   endtask

   task automatic resetDut(input int d, input int cycles);
      @(posedge clk); #1;
      rst[d] = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst[d] = 1'b0;
   endtask

   // Presents an op, waits (bounded) for the grant and drops valid just after
   // the handshake edge. Returns at posedge+1 of the first EXEC cycle.
   task automatic applyStimulus(input string tag, input int d, input bit id,
                                input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
      int   n;
      logic rdy;
      n = 0;
      drive(d, id, 1'b1, a, b, f);
      @(negedge clk);
      rdy = id ? r1r[d] : r0r[d];
      while (!rdy && n < 50) begin
         n++;
         @(negedge clk);
         rdy = id ? r1r[d] : r0r[d];
      end
      checkOutput({tag, "_grant"}, {7'd0, rdy}, 8'h01);
      @(posedge clk); #1;
      drive(d, id, 1'b0, 4'h0, 4'h0, 3'b000);
   endtask

   // Counts cycles from the one after the handshake until res_valid shows up.
   task automatic waitResult(input string tag, input int d, output int lat);
      lat = 1;
      @(negedge clk);
      while (!resv[d] && lat < 60) begin
         lat++;
         @(negedge clk);
      end
      checkOutput({tag, "_valid"}, {7'd0, resv[d]}, 8'h01);
   endtask

   task automatic ackResult(input int d);
      resr[d] = 1'b1;
      @(posedge clk); #1;
      resr[d] = 1'b0;
   endtask

   task automatic runOp(input string tag, input int d, input bit id,
                        input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                        input logic [7:0] exp_data, input int exp_lat);
      int lat;
      applyStimulus(tag, d, id, a, b, f);
      waitResult(tag, d, lat);
      checkOutput({tag, "_latency"}, 8'(lat), 8'(exp_lat));
      checkOutput({tag, "_data"}, resd[d], exp_data);
      checkOutput({tag, "_id"}, {7'd0, resid[d]}, {7'd0, id});
      ackResult(d);
   endtask

   initial begin
      int  lat;
      bit  exp_id;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         resr[i] = 1'b0;
         drive(i, 1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
         drive(i, 1'b1, 1'b0, 4'h0, 4'h0, 3'b000);
      end

      // Reset held with both requesters asking: nothing may be granted.
      drive(0, 1'b0, 1'b1, 4'h1, 4'h2, 3'b000);
      drive(0, 1'b1, 1'b1, 4'h3, 4'h4, 3'b000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("rst_ready0", {7'd0, r0r[0]}, 8'h00);
         checkOutput("rst_ready1", {7'd0, r1r[0]}, 8'h00);
         checkOutput("rst_res_valid", {7'd0, resv[0]}, 8'h00);
         checkOutput("rst_res_data", resd[0], 8'h00);
         checkOutput("rst_busy", {7'd0, bsy[0]}, 8'h00);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
      drive(0, 1'b1, 1'b0, 4'h0, 4'h0, 3'b000);

      // Basic op and function sweep on the OP_DELAY=1 instance.
      runOp("add_carry", 0, 1'b0, 4'h9, 4'h8, 3'b000, 8'h11, 2);
      runOp("add_nocarry", 0, 1'b1, 4'h9, 4'h8, 3'b001, 8'h01, 2);
      runOp("sext_b", 0, 1'b0, 4'h0, 4'hA, 3'b010, 8'hFA, 2);
      runOp("concat", 0, 1'b1, 4'h3, 4'hC, 3'b101, 8'h3C, 2);
      runOp("or_reduce", 0, 1'b0, 4'h0, 4'h0, 3'b011, 8'h00, 2);
      runOp("and_reduce", 0, 1'b1, 4'hF, 4'hF, 3'b100, 8'h01, 2);
      runOp("unused_fn", 0, 1'b0, 4'h5, 4'h3, 3'b111, 8'h00, 2);

      // Both requesters valid for four ops: alternate vs. req0 always.
      for (int d = 0; d < 2; d++) begin
         resetDut(d, 2);
         drive(d, 1'b0, 1'b1, 4'h1, 4'h1, 3'b001);
         drive(d, 1'b1, 1'b1, 4'h2, 4'h2, 3'b001);
         for (int i = 0; i < 4; i++) begin
            exp_id = (d == 0) ? i[0] : 1'b0;
            waitResult("tie", d, lat);
            checkOutput("tie_id", {7'd0, resid[d]}, {7'd0, exp_id});
            checkOutput("tie_data", resd[d], exp_id ? 8'h04 : 8'h02);
            ackResult(d);
         end
         drive(d, 1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
         drive(d, 1'b1, 1'b0, 4'h0, 4'h0, 3'b000);
      end

      // Consumer stalls in DONE while req1 waits; result must hold.
      applyStimulus("stall", 0, 1'b0, 4'h3, 4'hC, 3'b101);
      waitResult("stall", 0, lat);
      drive(0, 1'b1, 1'b1, 4'hF, 4'hF, 3'b100);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_data", resd[0], 8'h3C);
         checkOutput("stall_id", {7'd0, resid[0]}, 8'h00);
         checkOutput("stall_valid", {7'd0, resv[0]}, 8'h01);
         checkOutput("stall_ready0", {7'd0, r0r[0]}, 8'h00);
         checkOutput("stall_ready1", {7'd0, r1r[0]}, 8'h00);
         @(negedge clk);
      end
      resr[0] = 1'b1;
      checkOutput("ack_cycle_ready1", {7'd0, r1r[0]}, 8'h00);
      @(posedge clk); #1;
      resr[0] = 1'b0;
      @(negedge clk);
      checkOutput("next_accept_ready1", {7'd0, r1r[0]}, 8'h01);
      checkOutput("next_accept_busy", {7'd0, bsy[0]}, 8'h00);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 4'h0, 4'h0, 3'b000);
      waitResult("pending", 0, lat);
      checkOutput("pending_latency", 8'(lat), 8'd2);
      checkOutput("pending_data", resd[0], 8'h01);
      checkOutput("pending_id", {7'd0, resid[0]}, 8'h01);
      ackResult(0);

      // OP_DELAY=4: normal op, then an op aborted by reset in its 2nd EXEC cycle.
      runOp("slow", 2, 1'b0, 4'h9, 4'h8, 3'b000, 8'h11, 5);
      applyStimulus("abort", 2, 1'b0, 4'h9, 4'h8, 3'b000);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("abort_res_valid", {7'd0, resv[2]}, 8'h00);
         checkOutput("abort_busy", {7'd0, bsy[2]}, 8'h00);
      end
      // A tie right after reset must go to req0 even though req0 won last.
      @(posedge clk); #1;
      drive(2, 1'b1, 1'b1, 4'hF, 4'hF, 3'b100);
      runOp("post_reset_tie", 2, 1'b0, 4'h3, 4'hC, 3'b101, 8'h3C, 5);
      drive(2, 1'b1, 1'b0, 4'h0, 4'h0, 3'b000);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
